// File: rtl/uio_bus_arbiter_pkg.sv
// Shared types for the uio pad-bank arbiter: FSM state encoding and an
// index-width helper used for owner, round-robin pointer and counters.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    // Bits needed to index n items; never less than one bit.
    function automatic int idx_width(input int n);
        if (n > 2) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Request/grant bundle between the internal requesters and the arbiter,
// including the pad-facing uio_out/uio_oe outputs.
interface uio_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uio_arb_pkg::*;

    localparam int OW = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ*8-1:0] req_oe;
    logic [NUM_REQ-1:0]   gnt;
    logic [OW-1:0]        owner;
    logic                 busy;
    logic [7:0]           uio_out;
    logic [7:0]           uio_oe;

    modport slave (
        input  req, req_data, req_oe,
        output gnt, owner, busy, uio_out, uio_oe
    );

    modport master (
        output req, req_data, req_oe,
        input  gnt, owner, busy, uio_out, uio_oe
    );

endinterface

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request bit found
// scanning upward from rr_ptr with wrap-around.
module rr_pick
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int OW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OW-1:0]      rr_ptr,
    output logic               valid,
    output logic [OW-1:0]      index
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [OW:0]          off_s;
    logic [OW:0]          sum_s;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then un-rotate.
    always_comb begin
        valid = 1'b0;
        off_s = '0;
        dbl_s = {req, req} >> rr_ptr;
        rot_s = dbl_s[NUM_REQ-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && rot_s[i]) begin
                valid = 1'b1;
                off_s = (OW+1)'(i);
            end else begin
                valid = valid;
            end
        end
        sum_s = {1'b0, rr_ptr} + off_s;
        if (sum_s >= (OW+1)'(NUM_REQ)) begin
            sum_s = sum_s - (OW+1)'(NUM_REQ);
        end else begin
            sum_s = sum_s;
        end
        index = sum_s[OW-1:0];
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the uio pad bank: one driver at a time, bounded
// tenure under contention, and a parked-bus turnaround between owners.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    uio_bus_arbiter_if.slave  bus
);

    localparam int OW = idx_width(NUM_REQ);
    localparam int HW = idx_width(MAX_HOLD);
    localparam int TW = idx_width(TURNAROUND);
    localparam logic [HW-1:0]      HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0]      TURN_LAST = TW'(TURNAROUND - 1);
    localparam logic [OW-1:0]      OWN_LAST  = OW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    arb_state_e         state_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [OW-1:0]      owner_r;
    logic [OW-1:0]      rr_ptr_r;
    logic [HW-1:0]      hold_cnt_r;
    logic [TW-1:0]      turn_cnt_r;

    logic               pick_valid_s;
    logic [OW-1:0]      pick_idx_s;
    logic               own_req_s;
    logic               others_s;
    logic               leave_s;
    logic [7:0]         uio_out_s;
    logic [7:0]         uio_oe_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OW      (OW)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_r),
        .valid  (pick_valid_s),
        .index  (pick_idx_s)
    );

    // Release and preemption both funnel into the same exit path.
    always_comb begin
        own_req_s = bus.req[owner_r];
        others_s  = |(bus.req & ~(ONE_HOT0 << owner_r));
        leave_s   = !own_req_s || ((hold_cnt_r == HOLD_LAST) && others_s);
    end

    // Arbitration FSM with registered grant/owner and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gnt_r      <= '0;
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            hold_cnt_r <= '0;
            turn_cnt_r <= '0;
        end else if (!ena) begin
            state_r    <= ST_IDLE;
            gnt_r      <= '0;
            owner_r    <= '0;
            hold_cnt_r <= '0;
            turn_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        state_r    <= ST_GRANT;
                        gnt_r      <= ONE_HOT0 << pick_idx_s;
                        owner_r    <= pick_idx_s;
                        hold_cnt_r <= '0;
                    end else begin
                        gnt_r      <= '0;
                    end
                end
                ST_GRANT: begin
                    if (leave_s) begin
                        state_r    <= ST_TURN;
                        gnt_r      <= '0;
                        turn_cnt_r <= '0;
                        rr_ptr_r   <= (owner_r == OWN_LAST) ? '0 : owner_r + OW'(1);
                    end else if (hold_cnt_r != HOLD_LAST) begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end
                ST_TURN: begin
                    if (turn_cnt_r != TURN_LAST) begin
                        turn_cnt_r <= turn_cnt_r + TW'(1);
                    end else if (pick_valid_s) begin
                        state_r    <= ST_GRANT;
                        gnt_r      <= ONE_HOT0 << pick_idx_s;
                        owner_r    <= pick_idx_s;
                        hold_cnt_r <= '0;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= '0;
                end
            endcase
        end
    end

    // Pads follow the registered owner only while granted; parked otherwise.
    always_comb begin
        if (state_r == ST_GRANT) begin
            uio_out_s = bus.req_data[{owner_r, 3'b000} +: 8];
            uio_oe_s  = bus.req_oe[{owner_r, 3'b000} +: 8];
        end else begin
            uio_out_s = 8'h00;
            uio_oe_s  = 8'h00;
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.owner   = owner_r;
    assign bus.busy    = (state_r != ST_IDLE);
    assign bus.uio_out = uio_out_s;
    assign bus.uio_oe  = uio_oe_s;

endmodule
